// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
//   Shares one DRAM req/ack port between two masters:
//     port 0 : SPI flash-emulation read path
//     port 1 : sniffer capture write path (wr_fifo_read_ctrl)
//   One granted master's command is registered onto the DRAM port. The block
//   then waits for dram_ack, returns read data and a one-cycle ack to that
//   master, and inserts one dead cycle before it arbitrates again. Ties are
//   resolved round-robin against the last granted port.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   req0/addr0/we0/wdata0 -> ack0/rdata0   master port 0
//   req1/addr1/we1/wdata1 -> ack1/rdata1   master port 1
//   dram_req/dram_addr/dram_we/dram_data   registered DRAM command
//   dram_ack/dram_odata                    DRAM completion and read data
//   busy                transaction in progress
//   grant               index of current or last granted port
//   err                 aborted-transaction pulse
//
// Configuration
//   DRAM_ARB_TIMEOUT_EN  when defined, a WAIT that lasts TIMEOUT cycles without
//                        dram_ack is aborted with ack and err pulsed together.
//                        When undefined, WAIT lasts indefinitely and err is 0.
//
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              we0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              dram_req,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_we,
  output logic [DATA_W-1:0] dram_data,
  input  logic              dram_ack,
  input  logic [DATA_W-1:0] dram_odata,
  output logic              busy,
  output logic              grant,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last;
  logic              r_grant;
  logic              r_busy;
  logic              r_dreq;
  logic [ADDR_W-1:0] r_daddr;
  logic              r_dwe;
  logic [DATA_W-1:0] r_ddata;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_any;
  logic w_pick;

  assign w_any = req0 | req1;
  // On a tie the port that did not win last time is picked; otherwise the
  // lone requester. With no request w_pick is don't-care (not used).
  assign w_pick = (req0 && req1) ? ~r_last : req1;

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_tmo;

  // r_cnt is 0 in the first WAIT cycle, so TIMEOUT-1 marks the last one.
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign err   = r_err;
`else
  logic w_unused;

  assign w_unused = (TIMEOUT == 0);
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_busy   <= 1'b0;
      r_dreq   <= 1'b0;
      r_daddr  <= '0;
      r_dwe    <= 1'b0;
      r_ddata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          if (w_any) begin
            r_dreq  <= 1'b1;
            r_busy  <= 1'b1;
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_daddr <= w_pick ? addr1  : addr0;
            r_dwe   <= w_pick ? we1    : we0;
            r_ddata <= w_pick ? wdata1 : wdata0;
`ifdef DRAM_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (dram_ack) begin
            // dram_req must fall on this very edge or the controller restarts.
            r_dreq <= 1'b0;
            if (r_grant) begin
              r_ack1 <= 1'b1;
              if (!r_dwe) r_rdata1 <= dram_odata;
            end else begin
              r_ack0 <= 1'b1;
              if (!r_dwe) r_rdata0 <= dram_odata;
            end
            r_state <= S_REL;
          end
`ifdef DRAM_ARB_TIMEOUT_EN
          else if (w_tmo) begin
            r_dreq  <= 1'b0;
            r_err   <= 1'b1;
            if (r_grant) r_ack1 <= 1'b1;
            else         r_ack0 <= 1'b1;
            r_state <= S_REL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        S_REL: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
`ifdef DRAM_ARB_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign dram_req  = r_dreq;
  assign dram_addr = r_daddr;
  assign dram_we   = r_dwe;
  assign dram_data = r_ddata;
  assign busy      = r_busy;
  assign grant     = r_grant;

endmodule
